// File: rtl/tile_pkg.sv
// Shared types and helpers for the multi-channel tile spawner:
// channel state encoding, LFSR constants and the random-to-range mapping.
package tile_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAITING = 2'd1,
      ARMED   = 2'd2,
      MOVING  = 2'd3
   } tile_state_t;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
      logic [31:0] d;
      d = {v, v} << n;
      rotl16 = d[31:16];
   endfunction

   // min + floor(r * span / 2^16); the product fits comfortably in 32 bits,
   // so the result can never leave [min, max].
   function automatic int range_map(input logic [15:0] r, input int min, input int max);
      logic [31:0] span;
      logic [31:0] prod;
      span = 32'(max - min + 1);
      prod = {16'h0000, r} * span;
      range_map = min + int'(prod >> 16);
   endfunction

endpackage

// File: rtl/tile_channel_fsm.sv
// One tile channel: IDLE/WAITING/ARMED/MOVING state machine, wait counter
// and the attribute latches captured on every entry to WAITING.
module tile_channel_fsm #(
   parameter int COORD_W    = 11,
   parameter int MIN_X      = 0,
   parameter int MAX_X      = 500,
   parameter int MIN_W      = 32,
   parameter int MAX_W      = 640,
   parameter int MIN_H      = 32,
   parameter int MAX_H      = 480,
   parameter int MIN_WAIT   = 1,
   parameter int MAX_WAIT   = 40,
   parameter int NUM_COLORS = 7,
   parameter int Y_OFFSET   = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [15:0]               r,
   input  logic                      tick,
   input  logic                      freeze,
   input  logic                      start,
   input  logic                      end_level,
   input  logic                      exceed,
   input  logic                      grant,
   output logic                      req,
   output logic [1:0]                state,
   output logic signed [COORD_W-1:0] x,
   output logic signed [COORD_W-1:0] y,
   output logic signed [COORD_W-1:0] w,
   output logic signed [COORD_W-1:0] h,
   output logic [2:0]                color
);
   import tile_pkg::*;

   tile_state_t               state_q, state_d;
   logic                      enter_wait;
   logic [7:0]                cnt_q;
   logic signed [COORD_W-1:0] x_q, y_q, w_q, h_q;
   logic [2:0]                color_q;

   always_comb begin
      state_d    = state_q;
      enter_wait = 1'b0;
      if (end_level) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d    = WAITING;
                  enter_wait = 1'b1;
               end
            end
            WAITING: begin
               if (cnt_q == 8'd0) state_d = ARMED;
            end
            ARMED: begin
               if (grant) state_d = MOVING;
            end
            MOVING: begin
               if (exceed) begin
                  state_d    = WAITING;
                  enter_wait = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         if (enter_wait) begin
            x_q     <= COORD_W'(range_map(r, MIN_X, MAX_X));
            w_q     <= COORD_W'(range_map(r, MIN_W, MAX_W));
            h_q     <= COORD_W'(range_map(r, MIN_H, MAX_H));
            y_q     <= COORD_W'(Y_OFFSET - range_map(r, MIN_H, MAX_H));
            // Colour and wait use one byte each, scaled up to a 16-bit fraction.
            color_q <= 3'(range_map({r[15:8], 8'h00}, 0, NUM_COLORS - 1));
            cnt_q   <= 8'(range_map({r[7:0], 8'h00}, MIN_WAIT, MAX_WAIT));
         end else if (state_q == WAITING && cnt_q != 8'd0 && tick && !freeze) begin
            cnt_q <= cnt_q - 8'd1;
         end
      end
   end

   // req is held for as long as the channel is ARMED; grant is a
   // single-cycle acceptance that moves it to MOVING on the same edge.
   assign req   = (state_q == ARMED);
   assign state = state_q;
   assign x     = x_q;
   assign y     = y_q;
   assign w     = w_q;
   assign h     = h_q;
   assign color = color_q;

endmodule

// File: rtl/tile_spawner_multi.sv
// Multi-channel background tile spawner: shared LFSR, fixed-priority grant
// under a global visibility cap, and packing of per-channel attributes.
module tile_spawner_multi #(
   parameter int NUM_TILES   = 4,
   parameter int COORD_W     = 11,
   parameter int MIN_X       = 0,
   parameter int MAX_X       = 500,
   parameter int MIN_W       = 32,
   parameter int MAX_W       = 640,
   parameter int MIN_H       = 32,
   parameter int MAX_H       = 480,
   parameter int MIN_WAIT    = 1,
   parameter int MAX_WAIT    = 40,
   parameter int NUM_COLORS  = 7,
   parameter int MAX_VISIBLE = 2,
   parameter int Y_OFFSET    = 32
) (
   input  logic                           clk,
   input  logic                           resetN,
   input  logic                           startOfLevel,
   input  logic                           endLevel,
   input  logic                           oneTensSec,
   input  logic                           freeze,
   input  logic [15:0]                    seed,
   input  logic [NUM_TILES-1:0]           exceed,
   output logic [NUM_TILES-1:0]           visible,
   output logic [NUM_TILES-1:0]           loadAttributes,
   output logic [NUM_TILES*COORD_W-1:0]   topLeftX,
   output logic [NUM_TILES*COORD_W-1:0]   topLeftY,
   output logic [NUM_TILES*COORD_W-1:0]   rectWidth,
   output logic [NUM_TILES*COORD_W-1:0]   rectHeight,
   output logic [NUM_TILES*3-1:0]         colorCode,
   output logic [3:0]                     activeCount,
   output logic [NUM_TILES*2-1:0]         state_dbg
);
   import tile_pkg::*;

   logic [15:0]          lfsr_q, lfsr_cur, seed_eff;
   logic                 all_idle, load_seed, found;
   logic [NUM_TILES-1:0] req, grant;

   always_comb begin
      all_idle = 1'b1;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (state_dbg[2*i +: 2] != IDLE) all_idle = 1'b0;
      end
   end

   // On a seeded start the channels draw from the seed itself, so the first
   // attributes of a level depend only on the seed, not on when it started.
   assign seed_eff  = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
   assign load_seed = startOfLevel && all_idle;
   assign lfsr_cur  = load_seed ? seed_eff : lfsr_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) lfsr_q <= LFSR_DEFAULT;
      else         lfsr_q <= lfsr_step(lfsr_cur);
   end

   always_comb begin
      activeCount = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         activeCount = activeCount + {3'b000, visible[i]};
      end
   end

   always_comb begin
      grant = '0;
      found = 1'b0;
      if (!freeze && activeCount < 4'(MAX_VISIBLE)) begin
         for (int i = 0; i < NUM_TILES; i++) begin
            if (req[i] && !found) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_TILES; i++) begin : g_ch
      localparam int ROT = (3 * i) % 16;
      logic [15:0] r;
      assign r = rotl16(lfsr_cur, ROT);

      tile_channel_fsm #(
         .COORD_W   (COORD_W),
         .MIN_X     (MIN_X),
         .MAX_X     (MAX_X),
         .MIN_W     (MIN_W),
         .MAX_W     (MAX_W),
         .MIN_H     (MIN_H),
         .MAX_H     (MAX_H),
         .MIN_WAIT  (MIN_WAIT),
         .MAX_WAIT  (MAX_WAIT),
         .NUM_COLORS(NUM_COLORS),
         .Y_OFFSET  (Y_OFFSET)
      ) u_ch (
         .clk      (clk),
         .rst_n    (resetN),
         .r        (r),
         .tick     (oneTensSec),
         .freeze   (freeze),
         .start    (startOfLevel),
         .end_level(endLevel),
         .exceed   (exceed[i]),
         .grant    (grant[i]),
         .req      (req[i]),
         .state    (state_dbg[2*i +: 2]),
         .x        (topLeftX[i*COORD_W +: COORD_W]),
         .y        (topLeftY[i*COORD_W +: COORD_W]),
         .w        (rectWidth[i*COORD_W +: COORD_W]),
         .h        (rectHeight[i*COORD_W +: COORD_W]),
         .color    (colorCode[i*3 +: 3])
      );

      assign visible[i]        = (state_dbg[2*i +: 2] == MOVING);
      assign loadAttributes[i] = (state_dbg[2*i +: 2] == WAITING) ||
                                 (state_dbg[2*i +: 2] == ARMED);
   end

endmodule
